mul_div_unit: RTL and testbench

Iterative RV32M multiply/divide execution unit that consumes the 3-bit `mulDiv_op` code produced by the instruction decoder. Operands and the op code are accepted on a `start` pulse. The unit runs a fixed-latency shift-add or restoring-divide loop, then returns a registered 32-bit result with a one-cycle `done` pulse. It sits in the execute stage beside the ALU; its result is selected onto write-back when the decoder's `fn` selects the mul/div output.

---
 rtl/mul_div_unit.sv | 150 +++++++++++++++
 tb/tb_mul_div_unit.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one step per cycle over WIDTH iterations, then a single sign-fix cycle.
module mul_div_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             start,
   input  logic [2:0]       mulDiv_op,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

   localparam logic [5:0] LastIter = 6'(WIDTH - 1);

   state_e             state_q, state_d;
   logic [5:0]         cnt_q, cnt_d;
   logic [2:0]         op_q, op_d;
   logic               sa_q, sa_d, sb_q, sb_d;
   logic [WIDTH-1:0]   oper_q, oper_d;   // |multiplicand| or |divisor|
   logic [2*WIDTH-1:0] acc_q, acc_d;     // product, or {remainder, dividend/quotient}
   logic               done_q, done_d;
   logic [WIDTH-1:0]   result_q, result_d;

   logic               in_is_div, a_signed, b_signed, sa_in, sb_in;
   logic [WIDTH-1:0]   a_abs, b_abs;
   logic [WIDTH:0]     mul_sum, rem_sh, trial;
   logic               q_bit;
   logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;
   logic [WIDTH-1:0]   mul_res, quot, rem, q_fix, r_fix, div_res, fix_res;

   // Operand decode: which inputs are signed and their magnitudes
   always_comb begin
      in_is_div = mulDiv_op[2];
      a_signed  = in_is_div ? mulDiv_op[0] : (mulDiv_op == 3'b001 || mulDiv_op == 3'b010);
      b_signed  = in_is_div ? mulDiv_op[0] : (mulDiv_op == 3'b001);
      sa_in     = a_signed & op_a[WIDTH-1];
      sb_in     = b_signed & op_b[WIDTH-1];
      a_abs     = sa_in ? -op_a : op_a;
      b_abs     = sb_in ? -op_b : op_b;
   end

   // One iteration of shift-add multiply and of restoring divide
   always_comb begin
      mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, oper_q} : '0);
      mul_next = {mul_sum, acc_q[WIDTH-1:1]};
      rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      trial    = rem_sh - {1'b0, oper_q};
      // No borrow means the trial subtraction fits: keep it and set the quotient bit
      q_bit    = ~trial[WIDTH];
      div_next = {(q_bit ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], q_bit};
   end

   // Sign correction and result selection applied in the fix cycle
   always_comb begin
      prod_fix = (sa_q ^ sb_q) ? -acc_q : acc_q;
      mul_res  = (op_q[1:0] == 2'b00) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
      quot     = acc_q[WIDTH-1:0];
      rem      = acc_q[2*WIDTH-1:WIDTH];
      // Divide by zero leaves an all-ones quotient, which must not be negated
      q_fix    = ((sa_q ^ sb_q) && (oper_q != '0)) ? -quot : quot;
      r_fix    = sa_q ? -rem : rem;
      div_res  = op_q[1] ? r_fix : q_fix;
      fix_res  = op_q[2] ? div_res : mul_res;
   end

   // Next-state logic for the control FSM and datapath registers
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      sa_d     = sa_q;
      sb_d     = sb_q;
      oper_d   = oper_q;
      acc_d    = acc_q;
      done_d   = 1'b0;
      result_d = result_q;
      unique case (state_q)
         StIdle: begin
            if (start && !flush) begin
               state_d = StCalc;
               op_d    = mulDiv_op;
               sa_d    = sa_in;
               sb_d    = sb_in;
               cnt_d   = '0;
               if (in_is_div) begin
                  oper_d = b_abs;
                  acc_d  = {{WIDTH{1'b0}}, a_abs};
               end else begin
                  oper_d = a_abs;
                  acc_d  = {{WIDTH{1'b0}}, b_abs};
               end
            end
         end
         StCalc: begin
            if (flush) begin
               state_d = StIdle;
            end else begin
               acc_d = op_q[2] ? div_next : mul_next;
               cnt_d = cnt_q + 6'd1;
               if (cnt_q == LastIter) state_d = StFix;
            end
         end
         StFix: begin
            state_d = StIdle;
            if (!flush) begin
               result_d = fix_res;
               done_d   = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and datapath registers with asynchronous clear
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         op_q     <= '0;
         sa_q     <= 1'b0;
         sb_q     <= 1'b0;
         oper_q   <= '0;
         acc_q    <= '0;
         done_q   <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         sa_q     <= sa_d;
         sb_q     <= sb_d;
         oper_q   <= oper_d;
         acc_q    <= acc_d;
         done_q   <= done_d;
         result_q <= result_d;
      end
   end

   assign busy   = (state_q != StIdle);
   assign done   = done_q;
   assign result = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: scoreboard queue of expected results,
// one task per scenario with inline comparisons.
module tb_mul_div_unit;

   localparam int W = 32;
   localparam logic [2:0] OpMul   = 3'b000;
   localparam logic [2:0] OpMulh  = 3'b001;
   localparam logic [2:0] OpMulhsu = 3'b010;
   localparam logic [2:0] OpMulhu = 3'b011;
   localparam logic [2:0] OpDivu  = 3'b100;
   localparam logic [2:0] OpDiv   = 3'b101;
   localparam logic [2:0] OpRemu  = 3'b110;
   localparam logic [2:0] OpRem   = 3'b111;

   logic         clk = 1'b0;
   logic         nrst = 1'b0;
   logic         start = 1'b0;
   logic         flush = 1'b0;
   logic [2:0]   op = 3'b000;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         busy, done;
   logic [W-1:0] result;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int t0 = 0;
   int done_cnt = 0;
   logic [W-1:0] sb_q[$];

   mul_div_unit #(.WIDTH(W)) dut (
      .clk       (clk),
      .nrst      (nrst),
      .start     (start),
      .mulDiv_op (op),
      .op_a      (a),
      .op_b      (b),
      .flush     (flush),
      .busy      (busy),
      .done      (done),
      .result    (result)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (done === 1'b1) done_cnt <= done_cnt + 1;
   end

   // Caller must be at a negedge; returns just after the sampling edge (cycle 1)
   task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] e, input bit push);
      op = o;
      a = x;
      b = y;
      start = 1'b1;
      if (push) sb_q.push_back(e);
      @(posedge clk);
      #1;
      start = 1'b0;
      // scramble inputs: the unit must have latched them already
      op = ~o;
      a = ~x;
      b = ~y;
      t0 = cyc;
   endtask

   task automatic wait_done(output bit ok, output int lat);
      ok = 1'b0;
      lat = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            ok = 1'b1;
            lat = cyc - t0 + 1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      #3;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done); end
      checks++; if (result !== '0) begin failures++; $display("FAIL reset_result: got %h want 0", result); end
      @(negedge clk);
      nrst = 1'b1;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy: got %b want 0", busy); end
   endtask

   task automatic test_mul_high();
      logic [2:0]   ops[4] = '{OpMulh, OpMulhu, OpMulhsu, OpMul};
      logic [W-1:0] xs[4] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [W-1:0] ys[4] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0003};
      logic [W-1:0] es[4] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
      logic [W-1:0] exp;
      bit ok;
      int lat;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         issue(ops[i], xs[i], ys[i], es[i], 1'b1);
         @(negedge clk);
         checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mul_busy[%0d]: got %b want 1", i, busy); end
         wait_done(ok, lat);
         exp = sb_q.pop_front();
         checks++;
         if (!ok) begin
            failures++; $display("FAIL mul_timeout[%0d]: no done want done", i);
         end else begin
            checks++; if (result !== exp) begin failures++; $display("FAIL mul_result[%0d]: got %h want %h", i, result, exp); end
            checks++; if (lat !== 34) begin failures++; $display("FAIL mul_latency[%0d]: got %0d want 34", i, lat); end
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mul_busy_done[%0d]: got %b want 0", i, busy); end
            @(negedge clk);
            checks++; if (done !== 1'b0) begin failures++; $display("FAIL mul_pulse[%0d]: got %b want 0", i, done); end
         end
      end
   endtask

   task automatic test_div();
      logic [2:0]   ops[4] = '{OpDiv, OpRem, OpDivu, OpRemu};
      logic [W-1:0] xs[4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd7};
      logic [W-1:0] ys[4] = '{32'd2, 32'd2, 32'd2, 32'd2};
      logic [W-1:0] es[4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd3, 32'd1};
      logic [W-1:0] exp;
      bit ok;
      int lat;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         issue(ops[i], xs[i], ys[i], es[i], 1'b1);
         wait_done(ok, lat);
         exp = sb_q.pop_front();
         checks++;
         if (!ok) begin
            failures++; $display("FAIL div_timeout[%0d]: no done want done", i);
         end else begin
            checks++; if (result !== exp) begin failures++; $display("FAIL div_result[%0d]: got %h want %h", i, result, exp); end
            checks++; if (lat !== 34) begin failures++; $display("FAIL div_latency[%0d]: got %0d want 34", i, lat); end
         end
      end
   endtask

   task automatic test_corner();
      logic [2:0]   ops[5] = '{OpDivu, OpDiv, OpRem, OpDiv, OpRem};
      logic [W-1:0] xs[5] = '{32'd7, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'h8000_0000};
      logic [W-1:0] ys[5] = '{32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [W-1:0] es[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7, 32'h8000_0000, 32'd0};
      logic [W-1:0] exp;
      bit ok;
      int lat;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         issue(ops[i], xs[i], ys[i], es[i], 1'b1);
         wait_done(ok, lat);
         exp = sb_q.pop_front();
         checks++;
         if (!ok) begin
            failures++; $display("FAIL corner_timeout[%0d]: no done want done", i);
         end else begin
            checks++; if (result !== exp) begin failures++; $display("FAIL corner_result[%0d]: got %h want %h", i, result, exp); end
            checks++; if (lat !== 34) begin failures++; $display("FAIL corner_latency[%0d]: got %0d want 34", i, lat); end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] exp;
      bit ok;
      int lat, tf, dc;
      @(negedge clk);
      dc = done_cnt;
      issue(OpMul, 32'd6, 32'd7, 32'd42, 1'b1);
      tf = t0;
      repeat (10) @(negedge clk);
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_busy10: got %b want 1", busy); end
      // stray start while busy must be dropped
      op = OpDivu; a = 32'd1000; b = 32'd10; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(ok, lat);
      exp = sb_q.pop_front();
      checks++;
      if (!ok) begin
         failures++; $display("FAIL b2b_first_timeout: no done want done");
      end else begin
         checks++; if (result !== exp) begin failures++; $display("FAIL b2b_first_result: got %h want %h", result, exp); end
         checks++; if (lat !== 34) begin failures++; $display("FAIL b2b_first_latency: got %0d want 34", lat); end
         issue(OpDivu, 32'd100, 32'd7, 32'd14, 1'b1);
         wait_done(ok, lat);
         exp = sb_q.pop_front();
         checks++;
         if (!ok) begin
            failures++; $display("FAIL b2b_second_timeout: no done want done");
         end else begin
            checks++; if (result !== exp) begin failures++; $display("FAIL b2b_second_result: got %h want %h", result, exp); end
            checks++; if (cyc - tf + 1 !== 68) begin failures++; $display("FAIL b2b_second_cycle: got %0d want 68", cyc - tf + 1); end
         end
      end
      repeat (5) @(negedge clk);
      checks++; if (done_cnt !== dc + 2) begin failures++; $display("FAIL b2b_done_count: got %0d want %0d", done_cnt - dc, 2); end
   endtask

   task automatic test_flush();
      logic [W-1:0] exp;
      bit ok;
      int lat, dc;
      @(negedge clk);
      issue(OpMul, 32'd6, 32'd7, 32'd42, 1'b1);
      wait_done(ok, lat);
      exp = sb_q.pop_front();
      checks++; if (!ok || result !== exp) begin failures++; $display("FAIL flush_pre_result: got %h want %h", result, exp); end
      @(negedge clk);
      dc = done_cnt;
      issue(OpDiv, 32'hFFFF_FF9C, 32'd7, 32'd0, 1'b0);
      repeat (15) @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_busy16: got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL flush_done16: got %b want 0", done); end
      checks++; if (result !== 32'd42) begin failures++; $display("FAIL flush_result_kept: got %h want %h", result, 32'd42); end
      // flush in idle blocks a simultaneous start
      op = OpMul; a = 32'd3; b = 32'd3; start = 1'b1; flush = 1'b1;
      @(posedge clk);
      #1 begin start = 1'b0; flush = 1'b0; end
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_idle_busy: got %b want 0", busy); end
      repeat (40) @(negedge clk);
      checks++; if (done_cnt !== dc) begin failures++; $display("FAIL flush_no_done: got %0d want 0", done_cnt - dc); end
      issue(OpRemu, 32'd100, 32'd7, 32'd2, 1'b1);
      wait_done(ok, lat);
      exp = sb_q.pop_front();
      checks++;
      if (!ok) begin
         failures++; $display("FAIL flush_after_timeout: no done want done");
      end else begin
         checks++; if (result !== exp) begin failures++; $display("FAIL flush_after_result: got %h want %h", result, exp); end
         checks++; if (lat !== 34) begin failures++; $display("FAIL flush_after_latency: got %0d want 34", lat); end
      end
   endtask

   task automatic test_async_reset();
      logic [W-1:0] exp;
      bit ok;
      int lat;
      @(negedge clk);
      issue(OpDivu, 32'd100, 32'd7, 32'd0, 1'b0);
      repeat (10) @(negedge clk);
      #2 nrst = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL arst_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL arst_done: got %b want 0", done); end
      checks++; if (result !== '0) begin failures++; $display("FAIL arst_result: got %h want 0", result); end
      @(negedge clk);
      nrst = 1'b1;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL arst_idle: got %b want 0", busy); end
      issue(OpMulhu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1);
      wait_done(ok, lat);
      exp = sb_q.pop_front();
      checks++;
      if (!ok) begin
         failures++; $display("FAIL arst_after_timeout: no done want done");
      end else begin
         checks++; if (result !== exp) begin failures++; $display("FAIL arst_after_result: got %h want %h", result, exp); end
         checks++; if (lat !== 34) begin failures++; $display("FAIL arst_after_latency: got %0d want 34", lat); end
      end
   endtask

   initial begin
      test_reset();
      test_mul_high();
      test_div();
      test_corner();
      test_back_to_back();
      test_flush();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached want completion");
      $fatal(1, "watchdog");
   end

endmodule
